bcd_seq_alu: RTL and testbench

//   Multi-digit packed-BCD add/subtract engine. Operands arrive through a

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_add2.sv | 25 ++
 rtl/bcd_seq_alu.sv | 110 +++++++++++
 tb/tb_bcd_seq_alu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the sequential packed-BCD add/subtract engine.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] nines_comp(input logic [3:0] digit);
      return BCD_MAX - digit;
   endfunction

   function automatic logic is_bcd(input logic [3:0] digit);
      return digit <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_add2.sv
// Combinational two-digit BCD adder; the single instance is time-shared across bytes.
module bcd_add2
   import bcd_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   logic [4:0] t_lo, t_hi;
   logic       c_lo;

   // Decide the correction from the full 5-bit sum so sums of 16..19 still carry.
   always_comb begin
      t_lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
      c_lo = t_lo > {1'b0, BCD_MAX};
      t_hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c_lo};
      cout = t_hi > {1'b0, BCD_MAX};
      s[3:0] = c_lo ? t_lo[3:0] + 4'd6 : t_lo[3:0];
      s[7:4] = cout ? t_hi[3:0] + 4'd6 : t_hi[3:0];
   end

endmodule

// File: rtl/bcd_seq_alu.sv
// Multi-digit packed-BCD add/subtract: one byte per cycle through a shared adder,
// LSB byte first, with the decimal carry chained between bytes.
module bcd_seq_alu
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_op,
   input  logic [4*DIGITS-1:0] in_a,
   input  logic [4*DIGITS-1:0] in_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_s,
   output logic                out_cout,
   output logic                out_err
);

   localparam int W      = 4 * DIGITS;
   localparam int NBYTES = DIGITS / 2;
   localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t                  state, state_nx;
   logic [IW-1:0]           idx;
   logic [NBYTES-1:0][7:0]  a_r, b_r, s_r;
   logic                    carry, cout_r, err_r;
   logic [W-1:0]            b_prep;
   logic                    bad;
   logic                    accept, last;
   logic [7:0]              byte_s;
   logic                    byte_c;

   // Subtraction runs as A + nines(B) + 1, so B is complemented once at accept.
   always_comb begin
      b_prep = '0;
      bad    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         b_prep[4*i +: 4] = in_op ? nines_comp(in_b[4*i +: 4]) : in_b[4*i +: 4];
         if (!is_bcd(in_a[4*i +: 4]) || !is_bcd(in_b[4*i +: 4]))
            bad = 1'b1;
      end
   end

   assign accept = in_valid && (state == IDLE);
   assign last   = (idx == IW'(NBYTES - 1));

   bcd_add2 u_add (
      .a    (a_r[idx]),
      .b    (b_r[idx]),
      .cin  (carry),
      .s    (byte_s),
      .cout (byte_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = bad ? DONE : RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         s_r    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               a_r    <= in_a;
               b_r    <= b_prep;
               carry  <= in_op;
               idx    <= '0;
               s_r    <= '0;
               cout_r <= 1'b0;
               err_r  <= bad;
            end
            RUN: begin
               s_r[idx] <= byte_s;
               carry    <= byte_c;
               idx      <= idx + 1'b1;
               if (last) cout_r <= byte_c;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_s     = s_r;
   assign out_cout  = cout_r;
   assign out_err   = err_r;

endmodule

// File: tb/tb_bcd_seq_alu.sv
// Directed + small random bench for bcd_seq_alu with an integer reference model.
module tb_bcd_seq_alu;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;
   localparam int NBYTES = DIGITS / 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_op = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_s;
   logic         out_cout;
   logic         out_err;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bcd_seq_alu #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_cout  (out_cout),
      .out_err   (out_err)
   );

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   pw = 1;
      int   r;
      bit   bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         pw = pw * 10;
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      if (bad) begin
         e.s = '0; e.cout = 1'b0; e.err = 1'b1;
      end else if (!op) begin
         r = bcd2int(a) + bcd2int(b);
         e.cout = (r >= pw);
         e.s = int2bcd(r % pw);
         e.err = 1'b0;
      end else begin
         r = bcd2int(a) - bcd2int(b);
         e.cout = (r >= 0);
         e.s = int2bcd(r < 0 ? r + pw : r);
         e.err = 1'b0;
      end
      return e;
   endfunction

   // Latency counts rising edges after the accept edge until out_valid is seen.
   task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int hold);
      exp_t e;
      int   lat;
      sb.push_back(model(op, a, b));
      @(negedge clk);
      chk(tag, "in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = ~op; in_a = W'($urandom); in_b = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk(tag, "out_valid", 32'(out_valid), 32'd1);
      chk(tag, "latency", 32'(lat), e.err ? 32'd0 : 32'(NBYTES));
      chk(tag, "out_s", 32'(out_s), 32'(e.s));
      chk(tag, "out_cout", 32'(out_cout), 32'(e.cout));
      chk(tag, "out_err", 32'(out_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk(tag, "hold_valid", 32'(out_valid), 32'd1);
         chk(tag, "hold_s", 32'(out_s), 32'(e.s));
         chk(tag, "hold_cout", 32'(out_cout), 32'(e.cout));
         chk(tag, "hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk(tag, "post_valid", 32'(out_valid), 32'd0);
      chk(tag, "post_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", "in_ready", 32'(in_ready), 32'd1);
      chk("reset", "out_valid", 32'(out_valid), 32'd0);
      chk("reset", "out_s", 32'(out_s), 32'd0);
      chk("reset", "out_cout", 32'(out_cout), 32'd0);
      chk("reset", "out_err", 32'(out_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op(1'b0, 16'h1234, 16'h5678, "add_1234_5678", 0);
      chk("add_1234_5678", "const_s", 32'(model(1'b0, 16'h1234, 16'h5678).s), 32'h6912);
      run_op(1'b0, 16'h9999, 16'h0001, "add_9999_0001", 0);
      run_op(1'b0, 16'h0909, 16'h0909, "add_0909_0909", 0);
      run_op(1'b1, 16'h0100, 16'h0001, "sub_0100_0001", 0);
      run_op(1'b1, 16'h0001, 16'h0002, "sub_0001_0002", 0);
      run_op(1'b0, 16'h12A4, 16'h0001, "err_a", 0);
      run_op(1'b1, 16'h0005, 16'h00F0, "err_b", 0);
      run_op(1'b1, 16'h4321, 16'h1111, "hold_sub", 5);

      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < DIGITS; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(9));
            rb[4*i +: 4] = 4'($urandom_range(9));
         end
         run_op(1'($urandom_range(1)), ra, rb, $sformatf("rand%0d", n), 0);
      end

      // Abort mid-RUN: reset lands between edges while idx=1.
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b0; in_a = 16'h1234; in_b = 16'h5678;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset", "in_ready", 32'(in_ready), 32'd1);
      chk("mid_reset", "out_valid", 32'(out_valid), 32'd0);
      chk("mid_reset", "out_s", 32'(out_s), 32'd0);
      chk("mid_reset", "out_cout", 32'(out_cout), 32'd0);
      chk("mid_reset", "out_err", 32'(out_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_reset", "stays_idle", 32'(out_valid), 32'd0);

      run_op(1'b0, 16'h0001, 16'h0001, "add_after_reset", 0);
      chk("add_after_reset", "const_s", 32'(model(1'b0, 16'h0001, 16'h0001).s), 32'h0002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
